// File: rtl/ps2_move_decoder_if.sv
// PS/2 pin pair plus the decoded movement flags and byte-level status.
// The decoder owns the master side; the pins are inputs to it.
interface ps2_move_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       p1_up;
    logic       p1_down;
    logic       p1_right;
    logic       p1_left;
    logic       p2_up;
    logic       p2_down;
    logic       p2_right;
    logic       p2_left;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output p1_up, p1_down, p1_right, p1_left,
        output p2_up, p2_down, p2_right, p2_left,
        output byte_valid, byte_data, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  p1_up, p1_down, p1_right, p1_left,
        input  p2_up, p2_down, p2_right, p2_left,
        input  byte_valid, byte_data, frame_err
    );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard receiver plus make/break scan-code decoder that produces
// held movement flags for two players (WASD and extended arrow keys).
module ps2_move_decoder #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_move_decoder_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    localparam int P1_UP    = 0;
    localparam int P1_DOWN  = 1;
    localparam int P1_RIGHT = 2;
    localparam int P1_LEFT  = 3;
    localparam int P2_UP    = 4;
    localparam int P2_DOWN  = 5;
    localparam int P2_RIGHT = 6;
    localparam int P2_LEFT  = 7;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fall, din;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          accept, err;
    logic          ext, brk;
    logic [7:0]    flags;

    // Sync flops reset high so an idle-high bus never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], bus.ps2_clk};
            dat_sync <= {dat_sync[0], bus.ps2_data};
        end
    end

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign din     = dat_sync[1];
    assign timeout = (state != IDLE) && !fall && (to_cnt == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst || fall || state == IDLE)
            to_cnt <= '0;
        else if (!timeout)
            to_cnt <= to_cnt + TW'(1);
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        accept    = 1'b0;
        err       = 1'b0;
        if (timeout) begin
            state_n = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!din) begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                DATA: begin
                    shreg_n   = {din, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = din;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (din && (^{par, shreg})) accept = 1'b1;
                    else                        err    = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            par     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par     <= par_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.byte_valid <= 1'b0;
            bus.byte_data  <= 8'h00;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.byte_valid <= accept;
            bus.frame_err  <= err;
            if (accept) bus.byte_data <= shreg;
        end
    end

    // Decoding straight from the accepted byte lines flags up with byte_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            flags <= 8'h00;
        end else if (accept) begin
            case (shreg)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                default: begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (ext) begin
                        case (shreg)
                            8'h75: flags[P2_UP]    <= ~brk;
                            8'h72: flags[P2_DOWN]  <= ~brk;
                            8'h74: flags[P2_RIGHT] <= ~brk;
                            8'h6B: flags[P2_LEFT]  <= ~brk;
                            default: ;
                        endcase
                    end else begin
                        case (shreg)
                            8'h1D: flags[P1_UP]    <= ~brk;
                            8'h1B: flags[P1_DOWN]  <= ~brk;
                            8'h23: flags[P1_RIGHT] <= ~brk;
                            8'h1C: flags[P1_LEFT]  <= ~brk;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.p1_up    = flags[P1_UP];
    assign bus.p1_down  = flags[P1_DOWN];
    assign bus.p1_right = flags[P1_RIGHT];
    assign bus.p1_left  = flags[P1_LEFT];
    assign bus.p2_up    = flags[P2_UP];
    assign bus.p2_down  = flags[P2_DOWN];
    assign bus.p2_right = flags[P2_RIGHT];
    assign bus.p2_left  = flags[P2_LEFT];
endmodule
